multicycle_ctrl: RTL and testbench

Main sequencing controller for the multicycle ARM-subset datapath. It holds the instruction-phase FSM, the NZCV flags register and the condition check. It decodes the latched instruction fields and drives every datapath select and write-enable, one state per clock. The block sits beside the datapath in the top-level processor. It consumes Instr[31:12] and ALUFlags and drives the memory write strobe.

---
 rtl/multicycle_ctrl_pkg.sv | 78 +++++++
 rtl/multicycle_ctrl_condcheck.sv | 39 +++
 rtl/multicycle_ctrl.sv | 166 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, datapath
// select codes, instruction op/cmd fields, condition codes, and the cmd
// decode helpers used by both the execute and writeback states.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Unknown cmds fall back to ADD; their writeback is suppressed separately.
    function automatic logic [2:0] cmd_alu(input logic [3:0] cmd);
        case (cmd)
            CMD_SUB, CMD_CMP: return ALU_SUB;
            CMD_AND:          return ALU_AND;
            CMD_ORR:          return ALU_ORR;
            default:          return ALU_ADD;
        endcase
    endfunction

    // True for cmds that write their result back to Rd.
    function automatic logic cmd_writes(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
               (cmd == CMD_AND) || (cmd == CMD_ORR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_condcheck.sv
// ARM condition evaluation against stored NZCV flags.
// Ports:
//   cond_i    - instruction condition field
//   flags_i   - stored flags {N,Z,C,V}
//   cond_ex_o - 1 when the instruction should execute
module multicycle_ctrl_condcheck
    import multicycle_ctrl_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);
    logic n, z, c, v, ge;

    assign {n, z, c, v} = flags_i;
    assign ge = (n == v);

    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex_o = z;
            COND_NE: cond_ex_o = ~z;
            COND_CS: cond_ex_o = c;
            COND_CC: cond_ex_o = ~c;
            COND_MI: cond_ex_o = n;
            COND_PL: cond_ex_o = ~n;
            COND_VS: cond_ex_o = v;
            COND_VC: cond_ex_o = ~v;
            COND_HI: cond_ex_o = c & ~z;
            COND_LS: cond_ex_o = ~c | z;
            COND_GE: cond_ex_o = ge;
            COND_LT: cond_ex_o = ~ge;
            COND_GT: cond_ex_o = ~z & ge;
            COND_LE: cond_ex_o = z | ~ge;
            COND_AL: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;   // 1111 never executes
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Main sequencing controller for the multicycle ARM-subset datapath.
// Holds the instruction-phase FSM and the NZCV flags register, and decodes
// every datapath select / write enable from the current state plus the
// latched instruction fields.
// Ports:
//   clk, reset  - clock, async active-high reset
//   Instr       - IR[31:12]
//   ALUFlags    - NZCV from the ALU, sampled at the end of execute
//   *Write      - register / memory enables (forced 0 during reset)
//   AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl - selects
//   State       - current FSM state for debug
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        FPUWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic [3:0]  State
);
    state_t     state_q;
    logic [3:0] flags_q;
    logic       cond_ex;

    // Instr holds IR[31:12], so IR bit k sits at Instr[k-12].
    logic [3:0] cond, cmd, rd, unused_rn;
    logic [1:0] op;
    logic       i_bit, s_bit, u_bit, rd_pc;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign i_bit     = Instr[13];
    assign cmd       = Instr[12:9];
    assign u_bit     = Instr[11];
    assign s_bit     = Instr[8];   // S for data-processing, L for memory
    assign unused_rn = Instr[7:4];
    assign rd        = Instr[3:0];
    assign rd_pc     = (rd == 4'd15);

    multicycle_ctrl_condcheck u_condcheck (
        .cond_i    (cond),
        .flags_i   (flags_q),
        .cond_ex_o (cond_ex)
    );

    // Condition is evaluated on stored flags in DECODE, before this
    // instruction's own execute can update them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
        end else begin
            case (state_q)
                S_FETCH:    state_q <= S_DECODE;
                S_DECODE: begin
                    if (!cond_ex)
                        state_q <= S_FETCH;
                    else begin
                        case (op)
                            OP_MEM:  state_q <= S_MEMADR;
                            OP_BR:   state_q <= S_BRANCH;
                            OP_DP:   state_q <= i_bit ? S_EXECUTEI : S_EXECUTER;
                            default: state_q <= S_FETCH;   // undefined op
                        endcase
                    end
                end
                S_MEMADR:   state_q <= s_bit ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  state_q <= S_MEMWB;
                S_EXECUTER,
                S_EXECUTEI: begin
                    state_q <= S_ALUWB;
                    if (s_bit || (cmd == CMD_CMP))
                        flags_q <= ALUFlags;
                end
                default:    state_q <= S_FETCH;
            endcase
        end
    end

    logic pc_we, reg_we, mem_we, ir_we;

    always_comb begin
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        AdrSrc     = 1'b0;
        RegSrc     = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = SRCB_WD;
        ResultSrc  = RES_ALUOUT;
        ImmSrc     = IMM_DP;
        ALUControl = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ir_we     = 1'b1;
                pc_we     = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                if (op == OP_MEM) RegSrc = 2'b10;
                if (op == OP_BR) begin
                    RegSrc = 2'b01;
                    ImmSrc = IMM_BR;
                end
            end
            S_MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_MEM;
                ALUControl = u_bit ? ALU_ADD : ALU_SUB;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_we    = 1'b1;
                pc_we     = rd_pc;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_we = 1'b1;
            end
            S_EXECUTER: ALUControl = cmd_alu(cmd);
            S_EXECUTEI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = cmd_alu(cmd);
            end
            S_ALUWB: begin
                reg_we = cmd_writes(cmd);
                pc_we  = cmd_writes(cmd) && rd_pc;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_BR;
                ResultSrc = RES_ALURES;
                pc_we     = 1'b1;
            end
            default: ;
        endcase
    end

    // State is already FETCH during reset; only the enables need masking.
    assign PCWrite  = pc_we  & ~reset;
    assign RegWrite = reg_we & ~reset;
    assign MemWrite = mem_we & ~reset;
    assign IRWrite  = ir_we  & ~reset;
    assign FPUWrite = 1'b0;
    assign State    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, RegWrite, MemWrite, IRWrite, FPUWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;
    logic [3:0]  State;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .FPUWrite(FPUWrite), .AdrSrc(AdrSrc),
        .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .State(State)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [21:0] v;
        string       nm;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          checks = 0;
    int          fails  = 0;
    logic [21:0] act;

    assign act = {State, PCWrite, RegWrite, MemWrite, IRWrite, FPUWrite, AdrSrc,
                  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

    // {state, pcw, rw, mw, irw, fpu=0, adr, regsrc, srca, srcb, res, imm, alu}
    function automatic logic [21:0] mk(input logic [3:0] st, input logic pcw,
        input logic rw, input logic mw, input logic irw, input logic adr,
        input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
        input logic [1:0] res, input logic [1:0] imm, input logic [2:0] alu);
        return {st, pcw, rw, mw, irw, 1'b0, adr, rs, sa, sb, res, imm, alu};
    endfunction

    function automatic logic [21:0] v_fetch();
        return mk(4'd0, 1, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 3'b000);
    endfunction
    function automatic logic [21:0] v_rst();
        return mk(4'd0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 3'b000);
    endfunction
    function automatic logic [21:0] v_dec(input logic [1:0] rs, input logic [1:0] imm);
        return mk(4'd1, 0, 0, 0, 0, 0, rs, 2'b01, 2'b10, 2'b10, imm, 3'b000);
    endfunction

    task automatic chk(input string nm, input logic [21:0] got, input logic [21:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic push(input logic [21:0] v, input string nm);
        exp_t x;
        x.v = v; x.nm = nm;
        sb_q.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.nm, act, e.v);
        end
    end

    initial begin
        reset = 1'b1; Instr = 20'h0; ALUFlags = 4'h0;
        push(v_rst(), "reset_hold");
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;

        // ADD R1,R2,R3
        Instr = 20'hE0821; ALUFlags = 4'b0000;
        push(v_fetch(), "add_fetch");
        push(v_dec(2'b00, 2'b00), "add_decode");
        push(mk(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "add_execr");
        push(mk(4'd8, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "add_aluwb");
        step(4);

        // LDR R4,[R5,#8]
        Instr = 20'hE5954;
        push(v_fetch(), "ldr_fetch");
        push(v_dec(2'b10, 2'b00), "ldr_decode");
        push(mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 3'b000), "ldr_memadr");
        push(mk(4'd3, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "ldr_memread");
        push(mk(4'd4, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000), "ldr_memwb");
        step(5);

        // CMP R2,R0 with Z from the ALU
        Instr = 20'hE1520; ALUFlags = 4'b0100;
        push(v_fetch(), "cmp_fetch");
        push(v_dec(2'b00, 2'b00), "cmp_decode");
        push(mk(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001), "cmp_execr");
        push(mk(4'd8, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "cmp_aluwb");
        step(4);

        // ADD without S must not disturb stored flags
        Instr = 20'hE0821; ALUFlags = 4'b0000;
        push(v_fetch(), "adds0_fetch");
        push(v_dec(2'b00, 2'b00), "adds0_decode");
        push(mk(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "adds0_execr");
        push(mk(4'd8, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "adds0_aluwb");
        step(4);

        // BEQ taken (Z=1 stored)
        Instr = 20'h0A000;
        push(v_fetch(), "beq_fetch");
        push(v_dec(2'b01, 2'b10), "beq_decode");
        push(mk(4'd9, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 3'b000), "beq_branch");
        step(3);

        // BNE not taken: 2 cycles
        Instr = 20'h1A000;
        push(v_fetch(), "bne_fetch");
        push(v_dec(2'b01, 2'b10), "bne_decode");
        step(2);

        // STR R0,[R1,#-4]
        Instr = 20'hE5010;
        push(v_fetch(), "str_fetch");
        push(v_dec(2'b10, 2'b00), "str_decode");
        push(mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 3'b001), "str_memadr");
        push(mk(4'd5, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "str_memwrite");
        step(4);

        // ADD PC,R2,R3
        Instr = 20'hE082F;
        push(v_fetch(), "addpc_fetch");
        push(v_dec(2'b00, 2'b00), "addpc_decode");
        push(mk(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "addpc_execr");
        push(mk(4'd8, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "addpc_aluwb");
        step(4);

        // op=11 undefined
        Instr = 20'hEC000;
        push(v_fetch(), "op11_fetch");
        push(v_dec(2'b00, 2'b00), "op11_decode");
        step(2);

        // ADDS R2,R1,#imm with N from the ALU
        Instr = 20'hE2912; ALUFlags = 4'b1000;
        push(v_fetch(), "addsi_fetch");
        push(v_dec(2'b00, 2'b00), "addsi_decode");
        push(mk(4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000), "addsi_execi");
        push(mk(4'd8, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "addsi_aluwb");
        step(4);

        // BMI taken, then BEQ not taken (Z cleared by ADDS)
        Instr = 20'h4A000; ALUFlags = 4'b0000;
        push(v_fetch(), "bmi_fetch");
        push(v_dec(2'b01, 2'b10), "bmi_decode");
        push(mk(4'd9, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 3'b000), "bmi_branch");
        step(3);
        Instr = 20'h0A000;
        push(v_fetch(), "beq2_fetch");
        push(v_dec(2'b01, 2'b10), "beq2_decode");
        step(2);

        // Reset in the middle of MEMREAD
        Instr = 20'hE5954;
        push(v_fetch(), "ldr2_fetch");
        push(v_dec(2'b10, 2'b00), "ldr2_decode");
        push(mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 3'b000), "ldr2_memadr");
        push(mk(4'd3, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "ldr2_memread");
        step(3);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rst_async", act, v_rst());
        push(v_rst(), "rst_held");
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        Instr = 20'hE0821;
        push(v_fetch(), "post_rst_fetch");
        push(v_dec(2'b00, 2'b00), "post_rst_decode");
        push(mk(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "post_rst_execr");
        push(mk(4'd8, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000), "post_rst_aluwb");
        step(4);
        push(v_fetch(), "final_fetch");
        step(1);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
